serial_max_scan: RTL and testbench

SERIAL_MAX_SCAN -- requirements
Module: serial_max_scan

---
 rtl/serial_max_scan.sv | 169 ++++++++++++++++
 tb/tb_serial_max_scan.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_max_scan.sv
// Bit-serial magnitude comparator: latches two operands, scans them LSB first
// one bit per cycle, and reports max/min/greater/equal after WIDTH cycles.
module serial_max_scan #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] max_out,
  output logic [WIDTH-1:0] min_out,
  output logic             a_gt_b,
  output logic             eq
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0] a_r, a_s;
  logic [WIDTH-1:0] b_r, b_s;
  logic             gt_r, gt_s;
  logic             lt_r, lt_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [WIDTH-1:0] max_r, max_s;
  logic [WIDTH-1:0] min_r, min_s;
  logic             a_gt_b_r, a_gt_b_s;
  logic             eq_r, eq_s;

  logic             bit_a_s;
  logic             bit_b_s;
  logic             gt_fin_s;
  logic             lt_fin_s;

  // Decision flags after folding in the current bit; a higher differing bit
  // always overrides whatever the lower bits decided.
  always_comb begin
    bit_a_s  = a_r[cnt_r];
    bit_b_s  = b_r[cnt_r];
    gt_fin_s = gt_r;
    lt_fin_s = lt_r;
    if (bit_a_s != bit_b_s) begin
      gt_fin_s = bit_a_s;
      lt_fin_s = ~bit_a_s;
    end else begin
      gt_fin_s = gt_r;
      lt_fin_s = lt_r;
    end
  end

  // Next-state and next-datapath logic for the IDLE/SCAN controller.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    a_s      = a_r;
    b_s      = b_r;
    gt_s     = gt_r;
    lt_s     = lt_r;
    busy_s   = busy_r;
    done_s   = 1'b0;
    max_s    = max_r;
    min_s    = min_r;
    a_gt_b_s = a_gt_b_r;
    eq_s     = eq_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = SCAN;
          a_s     = a;
          b_s     = b;
          cnt_s   = {CNT_W{1'b0}};
          gt_s    = 1'b0;
          lt_s    = 1'b0;
          busy_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        gt_s = gt_fin_s;
        lt_s = lt_fin_s;
        if (cnt_r == LAST_IDX) begin
          state_s = IDLE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          if (gt_fin_s) begin
            max_s    = a_r;
            min_s    = b_r;
            a_gt_b_s = 1'b1;
            eq_s     = 1'b0;
          end else if (lt_fin_s) begin
            max_s    = b_r;
            min_s    = a_r;
            a_gt_b_s = 1'b0;
            eq_s     = 1'b0;
          end else begin
            max_s    = a_r;
            min_s    = a_r;
            a_gt_b_s = 1'b0;
            eq_s     = 1'b1;
          end
        end else begin
          // Counter stops at the last index, so it never wraps mid-scan.
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand, counter, flag and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= {CNT_W{1'b0}};
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      gt_r     <= 1'b0;
      lt_r     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      max_r    <= {WIDTH{1'b0}};
      min_r    <= {WIDTH{1'b0}};
      a_gt_b_r <= 1'b0;
      eq_r     <= 1'b0;
    end else begin
      cnt_r    <= cnt_s;
      a_r      <= a_s;
      b_r      <= b_s;
      gt_r     <= gt_s;
      lt_r     <= lt_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      max_r    <= max_s;
      min_r    <= min_s;
      a_gt_b_r <= a_gt_b_s;
      eq_r     <= eq_s;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign max_out = max_r;
  assign min_out = min_r;
  assign a_gt_b  = a_gt_b_r;
  assign eq      = eq_r;

endmodule

// File: tb/tb_serial_max_scan.sv
// Directed self-checking bench for serial_max_scan (WIDTH = 8).
module tb_serial_max_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] max_out;
  logic [7:0] min_out;
  logic       a_gt_b;
  logic       eq;

  int pass_cnt  = 0;
  int total_cnt = 0;

  serial_max_scan #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .max_out (max_out),
    .min_out (min_out),
    .a_gt_b  (a_gt_b),
    .eq      (eq)
  );

  always #5 clk = ~clk;

  // Called just after an accepting edge; lat = negedges until done (-1 on timeout).
  task automatic wait_done(input int chg_at, input logic [7:0] na, input logic [7:0] nb,
                           output int lat, output int busy_lo);
    lat     = -1;
    busy_lo = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = j;
        break;
      end
      if (busy !== 1'b1) busy_lo++;
      if (j == chg_at) begin
        a = na;
        b = nb;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({busy, done, max_out, min_out, a_gt_b, eq} !== 20'h00000)
      $display("FAIL reset_outputs: got %h expected %h",
               {busy, done, max_out, min_out, a_gt_b, eq}, 20'h00000);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({busy, done} !== 2'b00)
      $display("FAIL reset_idle: got %b expected %b", {busy, done}, 2'b00);
    else pass_cnt++;
  endtask

  task automatic test_gt;
    int lat, bl;
    @(negedge clk);
    a = 8'hA5; b = 8'h5A; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = 8'h00; b = 8'hFF;
    wait_done(-1, 8'h00, 8'h00, lat, bl);
    total_cnt++;
    if (lat !== 8) $display("FAIL gt_latency: got %0d expected %0d", lat, 8);
    else pass_cnt++;
    total_cnt++;
    if (bl !== 0) $display("FAIL gt_busy: got %0d low cycles expected %0d", bl, 0);
    else pass_cnt++;
    total_cnt++;
    if ({max_out, min_out, a_gt_b, eq} !== {8'hA5, 8'h5A, 1'b1, 1'b0})
      $display("FAIL gt_result: got %h expected %h",
               {max_out, min_out, a_gt_b, eq}, {8'hA5, 8'h5A, 1'b1, 1'b0});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({done, max_out, min_out, a_gt_b, eq} !== {1'b0, 8'hA5, 8'h5A, 1'b1, 1'b0})
      $display("FAIL gt_hold: got %h expected %h",
               {done, max_out, min_out, a_gt_b, eq}, {1'b0, 8'hA5, 8'h5A, 1'b1, 1'b0});
    else pass_cnt++;
  endtask

  task automatic test_lt_override;
    int lat, bl;
    @(negedge clk);
    a = 8'h01; b = 8'h80; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(-1, 8'h00, 8'h00, lat, bl);
    total_cnt++;
    if (lat !== 8) $display("FAIL lt_latency: got %0d expected %0d", lat, 8);
    else pass_cnt++;
    total_cnt++;
    if ({max_out, min_out, a_gt_b, eq} !== {8'h80, 8'h01, 1'b0, 1'b0})
      $display("FAIL lt_result: got %h expected %h",
               {max_out, min_out, a_gt_b, eq}, {8'h80, 8'h01, 1'b0, 1'b0});
    else pass_cnt++;
  endtask

  task automatic test_equal;
    int lat, bl;
    @(negedge clk);
    a = 8'h3C; b = 8'h3C; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(-1, 8'h00, 8'h00, lat, bl);
    total_cnt++;
    if (lat !== 8) $display("FAIL eq_latency: got %0d expected %0d", lat, 8);
    else pass_cnt++;
    total_cnt++;
    if ({max_out, min_out, a_gt_b, eq} !== {8'h3C, 8'h3C, 1'b0, 1'b1})
      $display("FAIL eq_result: got %h expected %h",
               {max_out, min_out, a_gt_b, eq}, {8'h3C, 8'h3C, 1'b0, 1'b1});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int lat, bl, dn;
    @(negedge clk);
    a = 8'h77; b = 8'h11; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy, done, max_out, min_out, a_gt_b, eq} !== 20'h00000)
      $display("FAIL midreset_outputs: got %h expected %h",
               {busy, done, max_out, min_out, a_gt_b, eq}, 20'h00000);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dn++;
    end
    total_cnt++;
    if (dn !== 0) $display("FAIL midreset_no_done: got %0d active cycles expected %0d", dn, 0);
    else pass_cnt++;
    // Second reset released together with start: must accept on the first edge.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; a = 8'h42; b = 8'h24; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(-1, 8'h00, 8'h00, lat, bl);
    total_cnt++;
    if (lat !== 8) $display("FAIL postreset_latency: got %0d expected %0d", lat, 8);
    else pass_cnt++;
    total_cnt++;
    if ({max_out, min_out, a_gt_b, eq} !== {8'h42, 8'h24, 1'b1, 1'b0})
      $display("FAIL postreset_result: got %h expected %h",
               {max_out, min_out, a_gt_b, eq}, {8'h42, 8'h24, 1'b1, 1'b0});
    else pass_cnt++;
  endtask

  task automatic test_hold_start;
    int lat, bl;
    @(negedge clk);
    a = 8'h11; b = 8'h22; start = 1'b1;
    @(posedge clk);
    wait_done(3, 8'hFF, 8'h00, lat, bl);
    total_cnt++;
    if (lat !== 8) $display("FAIL hold1_latency: got %0d expected %0d", lat, 8);
    else pass_cnt++;
    total_cnt++;
    if (bl !== 0) $display("FAIL hold1_busy: got %0d low cycles expected %0d", bl, 0);
    else pass_cnt++;
    total_cnt++;
    if ({max_out, min_out, a_gt_b, eq} !== {8'h22, 8'h11, 1'b0, 1'b0})
      $display("FAIL hold1_result: got %h expected %h",
               {max_out, min_out, a_gt_b, eq}, {8'h22, 8'h11, 1'b0, 1'b0});
    else pass_cnt++;
    @(posedge clk);
    wait_done(3, 8'h00, 8'hFF, lat, bl);
    total_cnt++;
    if (lat !== 8) $display("FAIL hold2_latency: got %0d expected %0d", lat, 8);
    else pass_cnt++;
    total_cnt++;
    if ({max_out, min_out, a_gt_b, eq} !== {8'hFF, 8'h00, 1'b1, 1'b0})
      $display("FAIL hold2_result: got %h expected %h",
               {max_out, min_out, a_gt_b, eq}, {8'hFF, 8'h00, 1'b1, 1'b0});
    else pass_cnt++;
    start = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({busy, done, max_out, min_out, a_gt_b, eq} !== {1'b0, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0})
      $display("FAIL hold_stop: got %h expected %h",
               {busy, done, max_out, min_out, a_gt_b, eq},
               {1'b0, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int lat, bl;
    @(negedge clk);
    a = 8'h05; b = 8'h03; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(-1, 8'h00, 8'h00, lat, bl);
    total_cnt++;
    if ({max_out, min_out, a_gt_b, eq} !== {8'h05, 8'h03, 1'b1, 1'b0})
      $display("FAIL b2b_first_result: got %h expected %h",
               {max_out, min_out, a_gt_b, eq}, {8'h05, 8'h03, 1'b1, 1'b0});
    else pass_cnt++;
    a = 8'h10; b = 8'h20; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(-1, 8'h00, 8'h00, lat, bl);
    total_cnt++;
    if (lat !== 8) $display("FAIL b2b_latency: got %0d expected %0d", lat, 8);
    else pass_cnt++;
    total_cnt++;
    if (bl !== 0) $display("FAIL b2b_busy: got %0d low cycles expected %0d", bl, 0);
    else pass_cnt++;
    total_cnt++;
    if ({max_out, min_out, a_gt_b, eq} !== {8'h20, 8'h10, 1'b0, 1'b0})
      $display("FAIL b2b_result: got %h expected %h",
               {max_out, min_out, a_gt_b, eq}, {8'h20, 8'h10, 1'b0, 1'b0});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_gt();
    test_lt_override();
    test_equal();
    test_reset_mid();
    test_hold_start();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
